// File: rtl/sw_lap_ctl.sv
// sw_lap_ctl: stopwatch / countdown timer with a lap-capture FIFO.
// A one-hot FSM (IDLE, COUNTING, PAUSED, DONE) drives a registered time
// counter. Laps are snapshots of the counter pushed into a small FIFO.
// Any return to IDLE flushes the FIFO and its sticky overflow flag.
module sw_lap_ctl #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 4,
    parameter int COUNT_DOWN = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       trig,
    input  logic                       split,
    input  logic [WIDTH-1:0]           preset,
    output logic [WIDTH-1:0]           count,
    output logic                       running,
    output logic                       paused,
    output logic                       done,
    output logic [WIDTH-1:0]           lap_data,
    output logic                       lap_valid,
    input  logic                       lap_rd,
    output logic [$clog2(DEPTH):0]     lap_count,
    output logic                       lap_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [WIDTH-1:0] TIME_ONE = WIDTH'(1);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        COUNTING = 4'b0010,
        PAUSED   = 4'b0100,
        DONE     = 4'b1000
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             expire;
    logic             capture;
    logic             pop;
    logic             full;
    logic             do_push;
    logic             ovf_set;
    logic             clear;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] lap_mem [DEPTH];

    // A down-counting tick that would leave count at zero ends the run
    assign expire  = (COUNT_DOWN != 0) && (state_q == COUNTING) && tick && (count == TIME_ONE);

    // Lap requests are honoured only while counting, and trig takes precedence
    assign capture = (state_q == COUNTING) && split && !trig;
    assign pop     = lap_rd && lap_valid;
    assign full    = (lap_count == CNT_FULL);
    assign do_push = capture && (!full || pop);
    assign ovf_set = capture && full && !pop;
    assign clear   = (state_d == IDLE);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; expiry beats a same-cycle trig so DONE always sees count=0
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    if ((COUNT_DOWN != 0) && (preset == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = COUNTING;
                    end
                end
            end
            COUNTING: begin
                if (expire) begin
                    state_d = DONE;
                end else if (trig) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (trig) begin
                    state_d = COUNTING;
                end else if (split) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (trig || split) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decode from the state register only
    always_comb begin
        running = (state_q == COUNTING);
        paused  = (state_q == PAUSED);
        done    = (state_q == DONE);
    end

    // Time counter: load in IDLE, step on tick while counting, hold when paused
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (COUNT_DOWN != 0) begin
                        count <= preset;
                    end else begin
                        count <= '0;
                    end
                end
                COUNTING: begin
                    if (tick) begin
                        if (COUNT_DOWN == 0) begin
                            count <= count + TIME_ONE;
                        end else if (count != '0) begin
                            count <= count - TIME_ONE;
                        end
                    end
                end
                PAUSED: begin
                    count <= count;
                end
                DONE: begin
                    count <= '0;
                end
                default: count <= '0;
            endcase
        end
    end

    // Lap FIFO control: pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_count    <= '0;
            lap_overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_count    <= '0;
            lap_overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !pop) begin
                lap_count <= lap_count + CNT_ONE;
            end else if (pop && !do_push) begin
                lap_count <= lap_count - CNT_ONE;
            end
            if (ovf_set) begin
                lap_overflow <= 1'b1;
            end
        end
    end

    // Lap storage captures the pre-tick count; contents are meaningless while empty
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            lap_mem[wr_ptr] <= count;
        end
    end

    assign lap_data  = lap_mem[rd_ptr];
    assign lap_valid = (lap_count != '0);

endmodule

// File: tb/tb_sw_lap_ctl.sv
// tb_sw_lap_ctl: directed bench for sw_lap_ctl.
// One up-counting instance (WIDTH=4) exercises wrap and the lap FIFO;
// one countdown instance (WIDTH=16) exercises expiry and preset loading.
// Expected laps are queued at capture time and popped when read out.
module tb_sw_lap_ctl;

    logic clk;
    logic reset;

    logic        u_tick, u_trig, u_split, u_lap_rd;
    logic [3:0]  u_preset, u_count, u_lap_data;
    logic        u_running, u_paused, u_done, u_lap_valid, u_lap_overflow;
    logic [2:0]  u_lap_count;

    logic        d_tick, d_trig, d_split, d_lap_rd;
    logic [15:0] d_preset, d_count, d_lap_data;
    logic        d_running, d_paused, d_done, d_lap_valid, d_lap_overflow;
    logic [2:0]  d_lap_count;

    int          n_checks;
    int          n_pass;
    int          n_fail;
    logic [3:0]  m_count;
    logic [3:0]  lap_q [$];

    sw_lap_ctl #(.WIDTH(4), .DEPTH(4), .COUNT_DOWN(0)) u_dut (
        .clk(clk), .reset(reset), .tick(u_tick), .trig(u_trig), .split(u_split),
        .preset(u_preset), .count(u_count), .running(u_running), .paused(u_paused),
        .done(u_done), .lap_data(u_lap_data), .lap_valid(u_lap_valid),
        .lap_rd(u_lap_rd), .lap_count(u_lap_count), .lap_overflow(u_lap_overflow)
    );

    sw_lap_ctl #(.WIDTH(16), .DEPTH(4), .COUNT_DOWN(1)) d_dut (
        .clk(clk), .reset(reset), .tick(d_tick), .trig(d_trig), .split(d_split),
        .preset(d_preset), .count(d_count), .running(d_running), .paused(d_paused),
        .done(d_done), .lap_data(d_lap_data), .lap_valid(d_lap_valid),
        .lap_rd(d_lap_rd), .lap_count(d_lap_count), .lap_overflow(d_lap_overflow)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic trig, input logic split, input logic tick, input logic rd);
        u_trig   = trig;
        u_split  = split;
        u_tick   = tick;
        u_lap_rd = rd;
        @(posedge clk);
        #1;
        u_trig   = 1'b0;
        u_split  = 1'b0;
        u_tick   = 1'b0;
        u_lap_rd = 1'b0;
    endtask

    task automatic apply_down(input logic trig, input logic split, input logic tick);
        d_trig  = trig;
        d_split = split;
        d_tick  = tick;
        @(posedge clk);
        #1;
        d_trig  = 1'b0;
        d_split = 1'b0;
        d_tick  = 1'b0;
    endtask

    task automatic up_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
            m_count = m_count + 4'd1;
        end
    endtask

    task automatic up_split();
        if (lap_q.size() < 4) lap_q.push_back(m_count);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic up_pop(input string tag);
        logic [3:0] exp_lap;
        exp_lap = lap_q.pop_front();
        check_output(tag, {28'd0, u_lap_data}, {28'd0, exp_lap});
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Directed scenario sequence
    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        m_count  = 4'd0;
        u_tick = 0; u_trig = 0; u_split = 0; u_lap_rd = 0; u_preset = 4'd0;
        d_tick = 0; d_trig = 0; d_split = 0; d_lap_rd = 0; d_preset = 16'd3;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_count", {28'd0, u_count}, 32'd0);
        check_output("rst_running", {31'd0, u_running}, 32'd0);
        check_output("rst_lap_valid", {31'd0, u_lap_valid}, 32'd0);
        check_output("rst_d_count", {16'd0, d_count}, 32'd0);
        reset = 1'b1;

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("d_first_edge_preset", {16'd0, d_count}, 32'd3);

        $display("[TB] up mode start/pause/resume");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_output("start_running", {31'd0, u_running}, 32'd1);
        up_ticks(5);
        check_output("count_5", {28'd0, u_count}, {28'd0, m_count});
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_output("paused_hold", {28'd0, u_count}, 32'd5);
        check_output("paused_flag", {31'd0, u_paused}, 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        up_ticks(2);
        check_output("resume_count_7", {28'd0, u_count}, 32'd7);
        check_output("resume_running", {31'd0, u_running}, 32'd1);

        $display("[TB] up mode wrap");
        up_ticks(8);
        check_output("count_15", {28'd0, u_count}, 32'd15);
        up_ticks(1);
        check_output("wrap_to_0", {28'd0, u_count}, 32'd0);
        check_output("wrap_running", {31'd0, u_running}, 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("paused_split_idle", {31'd0, u_running | u_paused}, 32'd0);

        $display("[TB] trig+split precedence");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        m_count = 4'd0;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        check_output("cnt_trig_split_paused", {31'd0, u_paused}, 32'd1);
        check_output("cnt_trig_split_nolap", {29'd0, u_lap_count}, 32'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        check_output("pau_trig_split_running", {31'd0, u_running}, 32'd1);

        $display("[TB] lap FIFO order");
        up_ticks(3);
        up_split();
        check_output("lap_visible_next_cycle", {31'd0, u_lap_valid}, 32'd1);
        up_ticks(5);
        up_split();
        up_ticks(4);
        up_split();
        check_output("lap_count_3", {29'd0, u_lap_count}, 32'd3);
        up_pop("pop_first");
        up_pop("pop_second");
        up_pop("pop_third");
        check_output("drained_valid", {31'd0, u_lap_valid}, 32'd0);

        $display("[TB] lap FIFO full/overflow");
        up_split();
        up_ticks(1);
        up_split();
        up_ticks(1);
        up_split();
        up_ticks(1);
        up_split();
        check_output("full_count", {29'd0, u_lap_count}, 32'd4);
        check_output("full_no_ovf", {31'd0, u_lap_overflow}, 32'd0);
        up_split();
        check_output("ovf_set", {31'd0, u_lap_overflow}, 32'd1);
        check_output("ovf_count", {29'd0, u_lap_count}, 32'd4);
        check_output("ovf_head", {28'd0, u_lap_data}, {28'd0, lap_q[0]});
        up_ticks(1);
        check_output("split_rd_head", {28'd0, u_lap_data}, {28'd0, lap_q.pop_front()});
        lap_q.push_back(m_count);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
        check_output("split_rd_count", {29'd0, u_lap_count}, 32'd4);
        check_output("split_rd_ovf_sticky", {31'd0, u_lap_overflow}, 32'd1);
        up_pop("pop_after_swap_a");
        up_pop("pop_after_swap_b");
        check_output("two_left", {29'd0, u_lap_count}, 32'd2);

        $display("[TB] async reset mid-count");
        #3;
        reset = 1'b0;
        #1;
        check_output("async_count", {28'd0, u_count}, 32'd0);
        check_output("async_running", {31'd0, u_running}, 32'd0);
        check_output("async_lap_count", {29'd0, u_lap_count}, 32'd0);
        check_output("async_lap_valid", {31'd0, u_lap_valid}, 32'd0);
        check_output("async_ovf", {31'd0, u_lap_overflow}, 32'd0);
        lap_q.delete();
        #2;
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] paused split flushes laps");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("refill_ovf", {31'd0, u_lap_overflow}, 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_output("refill_paused_count", {29'd0, u_lap_count}, 32'd4);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("flush_lap_count", {29'd0, u_lap_count}, 32'd0);
        check_output("flush_ovf", {31'd0, u_lap_overflow}, 32'd0);
        check_output("flush_state", {30'd0, u_running, u_paused}, 32'd0);

        $display("[TB] countdown");
        d_preset = 16'd3;
        apply_down(1'b0, 1'b0, 1'b0);
        apply_down(1'b1, 1'b0, 1'b0);
        check_output("d_start_count", {16'd0, d_count}, 32'd3);
        check_output("d_running", {31'd0, d_running}, 32'd1);
        apply_down(1'b0, 1'b0, 1'b1);
        apply_down(1'b0, 1'b0, 1'b1);
        check_output("d_count_1", {16'd0, d_count}, 32'd1);
        check_output("d_not_done_yet", {31'd0, d_done}, 32'd0);
        apply_down(1'b0, 1'b0, 1'b1);
        check_output("d_expired_count", {16'd0, d_count}, 32'd0);
        check_output("d_done", {31'd0, d_done}, 32'd1);
        check_output("d_stopped", {31'd0, d_running}, 32'd0);
        apply_down(1'b1, 1'b0, 1'b0);
        check_output("d_back_idle", {31'd0, d_done}, 32'd0);
        apply_down(1'b0, 1'b0, 1'b0);
        check_output("d_reload_preset", {16'd0, d_count}, 32'd3);
        d_preset = 16'd0;
        apply_down(1'b0, 1'b0, 1'b0);
        apply_down(1'b1, 1'b0, 1'b0);
        check_output("d_zero_preset_done", {31'd0, d_done}, 32'd1);
        apply_down(1'b0, 1'b1, 1'b0);
        check_output("d_split_leaves_done", {31'd0, d_done}, 32'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sw_lap_ctl.md
SW_LAP_CTL -- requirements
Module: sw_lap_ctl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 16, bit width of the elapsed-time counter and of each lap entry.
- DEPTH, 4, lap buffer entries; power of two, at least 2.
- COUNT_DOWN, 0, 0 selects count-up stopwatch; 1 selects countdown timer.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-low reset.
- tick, in, 1, time-base enable; one pulse per count unit.
- trig, in, 1, start/pause/resume pulse; single cycle, debounced upstream.
- split, in, 1, lap capture when counting, clear when paused; single cycle.
- preset, in, WIDTH, countdown start value; used only when COUNT_DOWN=1.
- count, out, WIDTH, current elapsed or remaining time (registered).
- running, out, 1, high in COUNTING.
- paused, out, 1, high in PAUSED.
- done, out, 1, high in DONE (countdown expired).
- lap_data, out, WIDTH, head entry of the lap buffer.
- lap_valid, out, 1, lap buffer not empty.
- lap_rd, in, 1, pops the head entry when lap_valid is high.
- lap_count, out, $clog2(DEPTH)+1, number of stored laps.
- lap_overflow, out, 1, sticky flag: a lap was dropped because the buffer was full.

Function
REQ-003 The FSM SHALL use one-hot states IDLE, COUNTING, PAUSED and DONE; DONE SHALL be reachable only when COUNT_DOWN=1.
REQ-004 running, paused and done SHALL decode from state only (Moore) with no combinational dependence on inputs.
REQ-005 IDLE: count SHALL load 0 (up mode) or preset (down mode) every cycle; trig SHALL move to COUNTING; split SHALL be ignored.
REQ-006 In down mode, trig in IDLE with preset=0 SHALL move to DONE instead of COUNTING.
REQ-007 COUNTING, trig: the FSM SHALL move to PAUSED.
REQ-008 COUNTING, split without trig: the FSM SHALL capture a lap and remain in COUNTING.
REQ-009 COUNTING, trig and split in the same cycle: trig SHALL win and no lap SHALL be captured.
REQ-010 COUNTING, up mode: each tick SHALL increment count, wrapping from 2^WIDTH-1 to 0 with no flag.
REQ-011 COUNTING, down mode: each tick SHALL decrement count; a tick when count=1 SHALL set count to 0 and move to DONE at the same edge.
REQ-012 PAUSED: count and tick SHALL be held and ignored respectively; trig SHALL move to COUNTING; split without trig SHALL move to IDLE.
REQ-013 PAUSED: trig and split in the same cycle SHALL resume counting only.
REQ-014 DONE: count SHALL hold 0; trig or split SHALL move to IDLE.
REQ-015 A lap capture SHALL store the count value present in the capture cycle, before any same-cycle tick update.
REQ-016 A captured lap SHALL be visible on lap_data and lap_valid one cycle after the capture cycle.
REQ-017 The lap buffer SHALL be FIFO ordered; lap_data SHALL show the oldest entry whenever lap_valid=1 and is don't-care otherwise.
REQ-018 lap_rd with lap_valid=1 SHALL pop the head at the clock edge; lap_rd with lap_valid=0 SHALL be ignored.
REQ-019 A capture into a full buffer with no same-cycle pop SHALL be dropped and SHALL set lap_overflow.
REQ-020 A capture and a pop in the same cycle SHALL both take effect, including when the buffer is full; lap_count SHALL be unchanged and lap_overflow not set.
REQ-021 Every transition into IDLE SHALL empty the lap buffer and clear lap_overflow at that edge.
REQ-022 lap_count SHALL equal the number of stored entries, 0..DEPTH.

Reset
REQ-023 reset low SHALL immediately force state IDLE, count=0, lap buffer empty, lap_count=0, lap_valid=0, lap_overflow=0, running=0, paused=0 and done=0, independent of clk.
REQ-024 After reset release, the first clk edge SHALL apply IDLE behaviour; in down mode count SHALL load preset at that edge.
REQ-025 Reset asserted mid-count or mid-pop SHALL discard all counter and lap state with no partial update.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Up mode, trig, 5 ticks, trig, 3 ticks -> count=5, paused=1; then trig, 2 ticks -> count=7, running=1.
- Up mode, WIDTH=4, counting with count=15 and one tick -> count=0, running=1.
- Splits at count=3, 8, 12 with DEPTH=4 -> lap_count=3; three pops return 3, 8, 12 in order; then lap_valid=0.
- DEPTH=4 full, fifth split -> lap_overflow=1, lap_count=4, head still the first lap; split+lap_rd on the same cycle -> lap_count=4, new lap appended.
- Down mode, preset=3, trig, 3 ticks -> count=0, done=1; trig -> IDLE, count=3.
- Counting with 2 laps stored, reset low mid-cycle -> all outputs 0 immediately; PAUSED+split -> IDLE, lap_count=0, lap_overflow=0.
